// File: rtl/wisc_pkg.sv
// Shared WISC definitions: ALU commands, opcodes and the decoded control bundle
// carried from ID into EX.
package wisc_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_PADDSB = 4'b0010;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_NAND   = 4'b1000;
  localparam logic [3:0] ALU_SLL    = 4'b1100;
  localparam logic [3:0] ALU_SRL    = 4'b1110;
  localparam logic [3:0] ALU_SRA    = 4'b1111;

  localparam logic [3:0] OPC_ADD    = 4'h0;
  localparam logic [3:0] OPC_PADDSB = 4'h1;
  localparam logic [3:0] OPC_SUB    = 4'h2;
  localparam logic [3:0] OPC_NAND   = 4'h3;
  localparam logic [3:0] OPC_XOR    = 4'h4;
  localparam logic [3:0] OPC_SLL    = 4'h5;
  localparam logic [3:0] OPC_SRL    = 4'h6;
  localparam logic [3:0] OPC_SRA    = 4'h7;
  localparam logic [3:0] OPC_LW     = 4'h8;
  localparam logic [3:0] OPC_SW     = 4'h9;
  localparam logic [3:0] OPC_LHB    = 4'hA;
  localparam logic [3:0] OPC_LLB    = 4'hB;
  localparam logic [3:0] OPC_B      = 4'hC;
  localparam logic [3:0] OPC_CALL   = 4'hD;
  localparam logic [3:0] OPC_RET    = 4'hE;
  localparam logic [3:0] OPC_HLT    = 4'hF;

  localparam int CTRL_ALU_CMD_W = 4;
  localparam int CTRL_FLAG_W    = 12;
  localparam int CTRL_W         = 1 + CTRL_ALU_CMD_W + CTRL_FLAG_W;

  typedef struct packed {
    logic                      valid;
    logic [CTRL_ALU_CMD_W-1:0] alu_cmd;
    logic                      alu_src;
    logic                      reg_wrt;
    logic                      mem_to_reg;
    logic                      mem_wrt;
    logic                      branch;
    logic                      call;
    logic                      ret;
    logic                      set_over;
    logic                      set_zero;
    logic                      llb;
    logic                      lhb;
    logic                      hlt;
  } ctrl_bundle_t;

  // A bubble clears every field, so no side effect can leak into EX.
  function automatic ctrl_bundle_t ctrl_bubble();
    ctrl_bundle_t c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_halt_drain_ctr.sv
// Halt-drain sequencer: once an HLT is captured into EX, waits for the older
// instructions to leave MEM/WB, then raises a sticky halt.
module halt_drain_ctr #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic capture_i,
  output logic halt_pending_o,
  output logic halt_o
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("halt_drain_ctr: DRAIN_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } drain_state_e;

  drain_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             halt_pending_q;
  logic             halt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      halt_pending_q <= 1'b0;
      halt_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (capture_i) begin
            state_q        <= S_DRAIN;
            halt_pending_q <= 1'b1;
            cnt_q          <= CNT_W'(DRAIN_CYCLES - 1);
          end
        end
        S_DRAIN: begin
          // Counter reaching zero marks the last older instruction leaving WB.
          if (cnt_q == '0) begin
            state_q <= S_HALTED;
            halt_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_HALTED: begin
          state_q <= S_HALTED;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign halt_pending_o = halt_pending_q;
  assign halt_o         = halt_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall/flush handling and ownership of the
// halt-drain sequence started by an HLT reaching EX.
module id_ex_pipe_reg
  import wisc_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int REG_ADDR_W   = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [3:0]            id_alu_cmd,
  input  logic                  id_alu_src,
  input  logic                  id_reg_wrt,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_wrt,
  input  logic                  id_branch,
  input  logic                  id_call,
  input  logic                  id_ret,
  input  logic                  id_set_over,
  input  logic                  id_set_zero,
  input  logic                  id_llb,
  input  logic                  id_lhb,
  input  logic                  id_hlt,
  input  logic [DATA_W-1:0]     id_rd1,
  input  logic [DATA_W-1:0]     id_rd2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [REG_ADDR_W-1:0] id_dst,
  output logic                  ex_valid,
  output logic [3:0]            ex_alu_cmd,
  output logic                  ex_alu_src,
  output logic                  ex_reg_wrt,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_wrt,
  output logic                  ex_branch,
  output logic                  ex_call,
  output logic                  ex_ret,
  output logic                  ex_set_over,
  output logic                  ex_set_zero,
  output logic                  ex_llb,
  output logic                  ex_lhb,
  output logic                  ex_hlt,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [REG_ADDR_W-1:0] ex_dst,
  output logic                  halt_pending,
  output logic                  halt
);

  ctrl_bundle_t          id_ctrl;
  ctrl_bundle_t          ctrl_d, ctrl_q;
  logic [DATA_W-1:0]     rd1_d, rd1_q;
  logic [DATA_W-1:0]     rd2_d, rd2_q;
  logic [DATA_W-1:0]     imm_d, imm_q;
  logic [DATA_W-1:0]     pc_d, pc_q;
  logic [REG_ADDR_W-1:0] dst_d, dst_q;

  logic halt_pending_w;
  logic halt_w;
  logic bubble;
  logic load;
  logic capture;

  assign id_ctrl = {id_valid, id_alu_cmd, id_alu_src, id_reg_wrt, id_mem_to_reg,
                    id_mem_wrt, id_branch, id_call, id_ret, id_set_over,
                    id_set_zero, id_llb, id_lhb, id_hlt};

  // Priority: draining HLT > flush > stall > load; an invalid ID slot loads as a bubble.
  assign bubble  = halt_pending_w | flush | (!stall & !id_valid);
  assign load    = !halt_pending_w & !flush & !stall & id_valid;
  assign capture = load & id_hlt;

  always_comb begin
    ctrl_d = ctrl_q;
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    dst_d  = dst_q;
    if (bubble) begin
      ctrl_d = ctrl_bubble();
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      pc_d   = '0;
      dst_d  = '0;
    end else if (load) begin
      ctrl_d = id_ctrl;
      rd1_d  = id_rd1;
      rd2_d  = id_rd2;
      imm_d  = id_imm;
      pc_d   = id_pc;
      dst_d  = id_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= ctrl_bubble();
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      dst_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      pc_q   <= pc_d;
      dst_q  <= dst_d;
    end
  end

  halt_drain_ctr #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_halt_drain_ctr (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .capture_i     (capture),
    .halt_pending_o(halt_pending_w),
    .halt_o        (halt_w)
  );

  assign ex_valid      = ctrl_q.valid;
  assign ex_alu_cmd    = ctrl_q.alu_cmd;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_wrt    = ctrl_q.reg_wrt;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_mem_wrt    = ctrl_q.mem_wrt;
  assign ex_branch     = ctrl_q.branch;
  assign ex_call       = ctrl_q.call;
  assign ex_ret        = ctrl_q.ret;
  assign ex_set_over   = ctrl_q.set_over;
  assign ex_set_zero   = ctrl_q.set_zero;
  assign ex_llb        = ctrl_q.llb;
  assign ex_lhb        = ctrl_q.lhb;
  assign ex_hlt        = ctrl_q.hlt;
  assign ex_rd1        = rd1_q;
  assign ex_rd2        = rd2_q;
  assign ex_imm        = imm_q;
  assign ex_pc         = pc_q;
  assign ex_dst        = dst_q;
  assign halt_pending  = halt_pending_w;
  assign halt          = halt_w;

endmodule
